// File: rtl/column_select_pkg.sv
// Shared constants and types for the column-select serial link (tx and rx sides).
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// BITS_PER_COLUMN : width of one 74HC595 stage in the chain
// SEL_BIT         : bit of each byte that selects its column (active low)
// EXTRA_BIT       : auxiliary bit carried in byte 0
// decode_state_t  : receiver decode tracker state
package column_select_pkg;

    localparam int BITS_PER_COLUMN = 8;
    localparam int SEL_BIT         = 0;
    localparam int EXTRA_BIT       = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,    // no valid latch seen since reset
        ST_TRACK = 2'd1,    // last latch decoded to exactly one column
        ST_ERR   = 2'd2     // last latch did not decode to a single column
    } decode_state_t;

endpackage

// File: rtl/column_select_rx_if.sv
// Serial pins of the column-select link as seen between transmitter and receiver.
// Latency: none (wires only).
// Backpressure: none; the link is a free-running shift interface.
//
// ser_clk      : shift clock, data sampled on its rising edge
// ser_data     : serial data, MSB of each byte first
// ser_stcp     : storage-latch strobe, latches on its rising edge
// ser_n_enable : output enable, active low
interface column_select_rx_if;

    logic ser_clk;
    logic ser_data;
    logic ser_stcp;
    logic ser_n_enable;

    // Transmitter drives the pins.
    modport master (
        output ser_clk,
        output ser_data,
        output ser_stcp,
        output ser_n_enable
    );

    // Receiver / monitor only observes them.
    modport slave (
        input ser_clk,
        input ser_data,
        input ser_stcp,
        input ser_n_enable
    );

endinterface

// File: rtl/serial_edge_sync.sv
// Synchronizes one serial pin into clk and flags its rising edge.
// Latency: SYNC_STAGES clk to level, rise valid the same cycle level first goes high.
// Backpressure: none; every input transition is observed if phases last >= 2 clk.
//
// Ports: clk, rst_n (async, active low), din (raw pin),
//        level (synchronized pin), rise (one-cycle pulse on a 0->1 of level).
module serial_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise
);

    // Edges are only reported once the synchronizer pipeline holds genuine
    // post-reset samples and the previous-value flop has seen one of them.
    // Without this, a pin that is already high when reset releases would
    // ripple through the zero-preloaded flops and look like a fresh edge.
    localparam logic [2:0] FILL_DONE = 3'(SYNC_STAGES + 1);

    logic       prev;
    logic [2:0] fill_cnt;

    if (SYNC_STAGES == 0) begin : g_direct
        assign level = din;
    end else begin : g_sync
        logic [SYNC_STAGES-1:0] sync_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync_q <= '0;
            end else begin
                sync_q[0] <= din;
                for (int i = 1; i < SYNC_STAGES; i++) begin
                    sync_q[i] <= sync_q[i-1];
                end
            end
        end

        assign level = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev     <= 1'b0;
            fill_cnt <= 3'd0;
        end else begin
            prev <= level;
            if (fill_cnt != FILL_DONE) begin
                fill_cnt <= fill_cnt + 3'd1;
            end
        end
    end

    assign rise = level & ~prev & (fill_cnt == FILL_DONE);

endmodule

// File: rtl/column_select_rx.sv
// Cycle-accurate receive model of the 74HC595 column-driver chain plus latch decoder.
// Latency: pin to q/bit_count/frame_error SYNC_STAGES+1 clk; decode outputs one clk after latch_pulse.
// Backpressure: none; the link cannot be stalled, inputs must meet the minimum phase width.
//
// Ports: clk, rst_n (async, active low), link (serial pins, slave modport),
//        q (storage register), q_oe (synchronized output enable), latch_pulse,
//        column_idx / column_valid / extra_bit (decoded latch image),
//        bit_count (shift edges since last latch, saturating), frame_error (sticky),
//        err_clear (synchronous clear of frame_error).
module column_select_rx
    import column_select_pkg::*;
#(
    parameter int CHAIN_LEN   = 2,
    parameter int SYNC_STAGES = 2,
    parameter int IDX_W       = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    column_select_rx_if.slave                    link,
    output logic [BITS_PER_COLUMN*CHAIN_LEN-1:0] q,
    output logic                                 q_oe,
    output logic                                 latch_pulse,
    output logic [IDX_W-1:0]                     column_idx,
    output logic                                 column_valid,
    output logic                                 extra_bit,
    output logic [7:0]                           bit_count,
    output logic                                 frame_error,
    input  logic                                 err_clear
);

    localparam int N = BITS_PER_COLUMN * CHAIN_LEN;

    // ------------------------------------------------------------------
    // Pin synchronizers. All four paths use the same stage count so data
    // stays aligned with the shift clock edge that samples it.
    // ------------------------------------------------------------------
    logic sck_rise;
    logic stcp_rise;
    logic data_s;
    logic oe_s;
    logic sck_lvl_unused;
    logic stcp_lvl_unused;
    logic data_rise_unused;
    logic oe_rise_unused;

    serial_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sck (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (link.ser_clk),
        .level (sck_lvl_unused),
        .rise  (sck_rise)
    );

    serial_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_stcp (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (link.ser_stcp),
        .level (stcp_lvl_unused),
        .rise  (stcp_rise)
    );

    serial_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_data (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (link.ser_data),
        .level (data_s),
        .rise  (data_rise_unused)
    );

    // The enable is synchronized already inverted so the zero preload means
    // "outputs disabled"; q_oe cannot flash high while the pipeline fills.
    serial_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_oe (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (~link.ser_n_enable),
        .level (oe_s),
        .rise  (oe_rise_unused)
    );

    // ------------------------------------------------------------------
    // Shift register, storage latch, bit counter and frame error.
    // ------------------------------------------------------------------
    logic [N-1:0] shift_q;
    logic         bad_frame;

    // A frame is good only if a whole number of bytes arrived. A saturated
    // count (255) is never a multiple of 8, so it is flagged as well.
    assign bad_frame = (bit_count == 8'd0) || (bit_count[2:0] != 3'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q     <= '0;
            q           <= '0;
            q_oe        <= 1'b0;
            latch_pulse <= 1'b0;
            bit_count   <= 8'd0;
            frame_error <= 1'b0;
        end else begin
            q_oe        <= oe_s;
            latch_pulse <= stcp_rise;

            // Older bits move toward the MSB; after a full byte sr[0] holds column bit 0.
            if (sck_rise) begin
                shift_q <= {shift_q[N-2:0], data_s};
            end

            // On a coincident shift+latch, q takes the pre-shift register
            // (non-blocking read of shift_q), like a 595 with tied clocks.
            if (stcp_rise) begin
                q         <= shift_q;
                bit_count <= sck_rise ? 8'd1 : 8'd0;
            end else if (sck_rise && (bit_count != 8'hFF)) begin
                bit_count <= bit_count + 8'd1;
            end

            // A new error takes priority over a clear in the same cycle.
            if (stcp_rise && bad_frame) begin
                frame_error <= 1'b1;
            end else if (err_clear) begin
                frame_error <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Latch decoder: find the single byte whose select bit is low.
    // ------------------------------------------------------------------
    logic             zero_seen;
    logic             zero_multi;
    logic [IDX_W-1:0] zero_idx;
    logic             one_zero;

    always_comb begin
        zero_seen  = 1'b0;
        zero_multi = 1'b0;
        zero_idx   = '0;
        for (int k = 0; k < CHAIN_LEN; k++) begin
            if (!q[k*BITS_PER_COLUMN + SEL_BIT]) begin
                if (zero_seen) begin
                    zero_multi = 1'b1;
                end
                zero_seen = 1'b1;
                zero_idx  = IDX_W'(k);
            end
        end
        one_zero = zero_seen & ~zero_multi;
    end

    // Decode tracker. latch_pulse is high in the first cycle q holds the new
    // image, so evaluating here makes the decoded outputs valid one clk later.
    decode_state_t state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            column_idx <= '0;
            extra_bit  <= 1'b0;
        end else if (latch_pulse) begin
            extra_bit <= q[EXTRA_BIT];
            if (one_zero) begin
                column_idx <= zero_idx;
            end
            case (state)
                ST_IDLE:  state <= one_zero ? ST_TRACK : ST_ERR;
                ST_TRACK: state <= one_zero ? ST_TRACK : ST_ERR;
                ST_ERR:   state <= one_zero ? ST_TRACK : ST_ERR;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    // column_valid is a direct decode of the registered state.
    assign column_valid = (state == ST_TRACK);

endmodule

// File: tb/tb_column_select_rx.sv
module tb_column_select_rx;

    localparam int  CL     = 2;
    localparam int  S      = 2;
    localparam int  N      = 8 * CL;
    localparam int  IW     = 1;
    localparam time SETTLE = 50;   // pin change -> decode outputs stable, with margin

    logic clk       = 1'b0;
    logic rst_n     = 1'b0;
    logic err_clear = 1'b0;

    always #5 clk = ~clk;

    column_select_rx_if link();

    logic [N-1:0]  q;
    logic          q_oe;
    logic          latch_pulse;
    logic [IW-1:0] column_idx;
    logic          column_valid;
    logic          extra_bit;
    logic [7:0]    bit_count;
    logic          frame_error;

    column_select_rx #(
        .CHAIN_LEN   (CL),
        .SYNC_STAGES (S)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .link         (link),
        .q            (q),
        .q_oe         (q_oe),
        .latch_pulse  (latch_pulse),
        .column_idx   (column_idx),
        .column_valid (column_valid),
        .extra_bit    (extra_bit),
        .bit_count    (bit_count),
        .frame_error  (frame_error),
        .err_clear    (err_clear)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model: updated at the moment the bench moves the pins.
    logic [N-1:0]  m_sr;
    logic [N-1:0]  m_q;
    int            m_bc;
    bit            m_fe;
    bit            m_valid;
    bit            m_extra;
    bit            m_oe;
    logic [IW-1:0] m_idx;
    int            m_latches = 0;

    bit  p_sck  = 1'b0;
    bit  p_data = 1'b0;
    bit  p_stcp = 1'b0;
    bit  p_nen  = 1'b1;
    time last_change = 0;
    bit  cmp_en = 1'b0;

    int  pulses_seen = 0;
    bit  lp_prev = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_sr    = '0;
        m_q     = '0;
        m_bc    = 0;
        m_fe    = 1'b0;
        m_valid = 1'b0;
        m_extra = 1'b0;
        m_idx   = '0;
    endtask

    task automatic model_apply(input bit sck_r, input bit d, input bit stcp_r);
        int zeros;
        int zk;
        if (stcp_r) begin
            m_q = m_sr;
            m_latches++;
            if (m_bc == 0 || (m_bc % 8) != 0 || m_bc >= 255) m_fe = 1'b1;
            zeros = 0;
            zk    = 0;
            for (int k = 0; k < CL; k++) begin
                if (m_q[8*k] == 1'b0) begin
                    zeros++;
                    zk = k;
                end
            end
            m_valid = (zeros == 1);
            if (zeros == 1) m_idx = IW'(zk);
            m_extra = m_q[1];
            m_bc    = 0;
        end
        if (sck_r) begin
            m_sr = {m_sr[N-2:0], d};
            if (m_bc < 255) m_bc++;
        end
    endtask

    task automatic set_pins(input bit sck, input bit d, input bit stcp, input bit nen);
        model_apply(sck & ~p_sck, d, stcp & ~p_stcp);
        p_sck  = sck;
        p_data = d;
        p_stcp = stcp;
        p_nen  = nen;
        m_oe   = ~nen;
        link.ser_clk      = sck;
        link.ser_data     = d;
        link.ser_stcp     = stcp;
        link.ser_n_enable = nen;
        last_change = $time;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic hold(input int lo, input int hi);
        repeat ($urandom_range(hi, lo)) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input bit d, input int hi);
        set_pins(1'b0, d, p_stcp, p_nen);
        hold(2, hi);
        set_pins(1'b1, d, p_stcp, p_nen);
        hold(2, hi);
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i], 6);
    endtask

    task automatic latch();
        set_pins(1'b0, p_data, 1'b1, p_nen);
        hold(2, 6);
        set_pins(1'b0, p_data, 1'b0, p_nen);
        hold(2, 6);
    endtask

    task automatic latch_coincident(input bit d);
        set_pins(1'b0, d, 1'b0, p_nen);
        hold(2, 6);
        set_pins(1'b1, d, 1'b1, p_nen);
        hold(2, 6);
        set_pins(1'b0, d, 1'b0, p_nen);
        hold(2, 6);
    endtask

    task automatic pulse_clear();
        err_clear = 1'b1;
        m_fe = 1'b0;
        last_change = $time;
        tick(1);
        err_clear = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_q"},            32'(q),            32'd0);
        chk({tag, "_q_oe"},         32'(q_oe),         32'd0);
        chk({tag, "_latch_pulse"},  32'(latch_pulse),  32'd0);
        chk({tag, "_column_idx"},   32'(column_idx),   32'd0);
        chk({tag, "_column_valid"}, 32'(column_valid), 32'd0);
        chk({tag, "_extra_bit"},    32'(extra_bit),    32'd0);
        chk({tag, "_bit_count"},    32'(bit_count),    32'd0);
        chk({tag, "_frame_error"},  32'(frame_error),  32'd0);
    endtask

    // Per-cycle comparison against the model once the pins have been quiet
    // long enough for every output to reflect the last change.
    always @(negedge clk) begin
        if (cmp_en && rst_n && ($time - last_change) >= SETTLE) begin
            chk("cmp_q",            32'(q),            32'(m_q));
            chk("cmp_bit_count",    32'(bit_count),    32'(m_bc));
            chk("cmp_frame_error",  32'(frame_error),  32'(m_fe));
            chk("cmp_column_valid", 32'(column_valid), 32'(m_valid));
            chk("cmp_column_idx",   32'(column_idx),   32'(m_idx));
            chk("cmp_extra_bit",    32'(extra_bit),    32'(m_extra));
            chk("cmp_q_oe",         32'(q_oe),         32'(m_oe));
            chk("cmp_latch_idle",   32'(latch_pulse),  32'd0);
        end
    end

    // Latch pulses are counted and must each be exactly one cycle wide.
    always @(negedge clk) begin
        if (latch_pulse) begin
            pulses_seen++;
            chk("latch_pulse_width", 32'(lp_prev), 32'd0);
        end
        lp_prev = latch_pulse;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pulses_before;
        link.ser_clk      = 1'b0;
        link.ser_data     = 1'b0;
        link.ser_stcp     = 1'b0;
        link.ser_n_enable = 1'b1;
        model_reset();
        m_oe = 1'b0;

        tick(3);
        check_zero("reset");
        rst_n = 1'b1;
        tick(6);
        last_change = $time;
        cmp_en = 1'b1;

        // q_oe latency: SYNC_STAGES+1 clocks from the pin.
        set_pins(1'b0, 1'b0, 1'b0, 1'b0);
        tick(2);
        chk("q_oe_before_latency", 32'(q_oe), 32'd0);
        tick(1);
        chk("q_oe_at_latency", 32'(q_oe), 32'd1);

        // Two bytes: first one ends up in the upper byte.
        send_byte(8'hFE);
        send_byte(8'hFF);
        latch();
        tick(6);
        chk("model_q_feff",   32'(m_q),          32'h0000FEFF);
        chk("q_feff",         32'(q),            32'h0000FEFF);
        chk("idx_feff",       32'(column_idx),   32'd1);
        chk("valid_feff",     32'(column_valid), 32'd1);
        chk("extra_feff",     32'(extra_bit),    32'd1);
        chk("fe_feff",        32'(frame_error),  32'd0);
        chk("bc_after_latch", 32'(bit_count),    32'd0);
        chk("pulses_first",   32'(pulses_seen),  32'd1);

        // Short frame raises the sticky error; clear it; a full frame keeps it clear.
        for (int i = 0; i < 7; i++) send_bit(1'(i & 1), 6);
        latch();
        tick(6);
        chk("model_fe_short", 32'(m_fe),        32'd1);
        chk("fe_short",       32'(frame_error), 32'd1);
        pulse_clear();
        chk("fe_cleared",     32'(frame_error), 32'd0);
        send_byte(8'hFF);
        send_byte(8'hFE);
        latch();
        tick(6);
        chk("fe_full_frame",  32'(frame_error), 32'd0);
        chk("idx_fffe",       32'(column_idx),  32'd0);

        // Shift and latch on the same edge: q keeps the pre-shift image.
        send_byte(8'hA5);
        latch_coincident(1'b1);
        tick(6);
        chk("q_low_coincident",  32'(q[7:0]),      32'h000000A5);
        chk("bc_coincident",     32'(bit_count),   32'd1);
        chk("fe_coincident",     32'(frame_error), 32'd0);
        chk("idx_coincident",    32'(column_idx),  32'd1);

        // Error and err_clear in the same cycle: error wins (bit_count is 1 here).
        set_pins(1'b0, p_data, 1'b1, p_nen);
        tick(2);
        err_clear = 1'b1;
        tick(1);
        err_clear = 1'b0;
        chk("latch_pulse_latency", 32'(latch_pulse), 32'd1);
        chk("fe_error_wins",       32'(frame_error), 32'd1);
        tick(1);
        chk("latch_pulse_drop",    32'(latch_pulse), 32'd0);
        set_pins(1'b0, p_data, 1'b0, p_nen);
        hold(2, 4);
        pulse_clear();

        // All-zero image: invalid, column_idx holds the last valid index.
        send_byte(8'h00);
        send_byte(8'h00);
        latch();
        tick(6);
        chk("valid_zero", 32'(column_valid), 32'd0);
        chk("idx_zero",   32'(column_idx),   32'd1);

        // Saturating bit counter.
        for (int i = 0; i < 300; i++) send_bit(1'($urandom_range(0, 1)), 2);
        tick(6);
        chk("bc_saturated", 32'(bit_count), 32'd255);
        latch();
        tick(6);
        chk("fe_saturated", 32'(frame_error), 32'd1);
        pulse_clear();

        // Randomized frames.
        for (int f = 0; f < 30; f++) begin
            int nbits;
            int c;
            logic [31:0] w;
            if ($urandom_range(0, 3) == 0) begin
                set_pins(p_sck, p_data, p_stcp, ~p_nen);
                hold(2, 4);
            end
            nbits = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 24)) : 16;
            w = $urandom;
            if ($urandom_range(0, 2) != 0) begin
                c = $urandom_range(0, CL - 1);
                w[0] = 1'b1;
                w[8] = 1'b1;
                w[8*c] = 1'b0;
            end
            for (int i = nbits - 1; i >= 0; i--) send_bit(w[i], 7);
            if ($urandom_range(0, 5) == 0) latch_coincident(1'($urandom_range(0, 1)));
            else latch();
            if ($urandom_range(0, 3) == 0) pulse_clear();
        end

        // Asynchronous reset mid-byte with ser_stcp and ser_clk held high.
        send_byte(8'h3C);
        set_pins(1'b0, 1'b1, 1'b1, 1'b0);
        hold(3, 5);
        for (int i = 0; i < 3; i++) send_bit(1'b1, 5);
        tick(6);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("async_reset");
        model_reset();
        pulses_before = pulses_seen;
        tick(3);
        rst_n = 1'b1;
        last_change = $time;
        tick(10);
        chk("no_spurious_latch", 32'(pulses_seen - pulses_before), 32'd0);
        chk("q_after_reset",     32'(q),                           32'd0);
        chk("bc_after_reset",    32'(bit_count),                   32'd0);
        chk("q_oe_after_reset",  32'(q_oe),                        32'd1);

        // Next frame starts from an empty shift register.
        set_pins(1'b0, 1'b0, 1'b0, p_nen);
        hold(2, 4);
        send_byte(8'hFE);
        latch();
        tick(6);
        chk("q_fresh_frame", 32'(q), 32'h000000FE);

        tick(4);
        chk("pulse_total", 32'(pulses_seen), 32'(m_latches));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/column_select_rx.md
Name: column_select_rx

Overview:
- Receive-side counterpart of the column-select serial link: a cycle-accurate model of the 74HC595 chain that the matrix column drivers present to the link.
- Samples ser_clk / ser_data / ser_stcp / ser_n_enable and shifts on ser_clk rising edges. Latches on ser_stcp rising edges.
- Decodes the latched image into active column index, extra bit and error flags.
- Used as an FPGA loopback checker and as the DUT-side monitor in column-select benches.

Parameters:
- CHAIN_LEN, 2, number of chained 8-bit shift registers (1..16).
- SYNC_STAGES, 2, synchronizer flops on each serial input (0..3). 0 means the inputs are already synchronous to clk.
- IDX_W, $clog2(CHAIN_LEN) min 1, width of column_idx.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- ser_clk  in  1  serial shift clock
- ser_data  in  1  serial data; sampled on ser_clk rising edge
- ser_stcp  in  1  storage-latch strobe; latches on rising edge
- ser_n_enable  in  1  output enable, active low
- q  out  8*CHAIN_LEN  storage register (parallel outputs)
- q_oe  out  1  synchronized !ser_n_enable
- latch_pulse  out  1  one-cycle pulse when q updates
- column_idx  out  IDX_W  index of the byte whose select bit is 0
- column_valid  out  1  exactly one select bit in q is 0
- extra_bit  out  1  q[EXTRA_BIT] of byte 0
- bit_count  out  8  rising edges since last latch, saturates at 255
- frame_error  out  1  sticky; set at latch if bit_count is 0 or not a multiple of 8
- err_clear  in  1  synchronous clear of frame_error

Behaviour:
- Reset (rst_n low, asynchronous): shift register = 0, q = 0, q_oe = 0, latch_pulse = 0, column_idx = 0, column_valid = 0, extra_bit = 0, bit_count = 0, frame_error = 0.
- Reset also preloads every synchronizer and previous-value flop to 0, so an input already high at release does not create a false edge.
- Sync path: ser_clk, ser_data, ser_stcp and ser_n_enable each pass through SYNC_STAGES flops. All four get equal delay, so data stays aligned with its clock.
- Edge detect: a registered previous value per input.
  - rise_sck = sck_s & ~sck_prev.
  - rise_stcp = stcp_s & ~stcp_prev.
- Input timing requirement: high and low phases of ser_clk and ser_stcp each last at least 2 clk when SYNC_STAGES > 0, and at least 1 clk when SYNC_STAGES = 0.
- Latency from input pin to register update: SYNC_STAGES + 1 clk.
- Shift on rise_sck: sr <= {sr[N-2:0], data_s}, where N = 8*CHAIN_LEN.
  - The transmitter sends MSB first, so after 8 bits sr[0] holds column bit 0.
  - Older bytes move toward sr[N-1].
- Latch on rise_stcp:
  - q <= sr. When rise_sck falls in the same cycle, q takes the pre-shift value, matching a 595 with tied clocks.
  - latch_pulse = 1 for exactly that cycle.
  - frame_error is evaluated from the pre-latch bit_count.
  - bit_count is then cleared to 0, or to 1 if rise_sck coincides.
- bit_count: increments on rise_sck and saturates at 255; the saturated value counts as a frame error.
- Decode (combinational from q, registered, so valid 1 clk after latch_pulse):
  - Select bit of byte k is q[8k+SEL_BIT].
  - column_valid = 1 iff exactly one select bit is 0.
  - column_idx = that k when column_valid = 1; otherwise it holds its previous value.
  - extra_bit = q[EXTRA_BIT].
- q_oe follows synchronized !ser_n_enable. Latching and decoding are independent of enable, as in the real part.
- frame_error is sticky until err_clear.
  - err_clear and a new error in the same cycle: the error wins (flag stays 1).
- Decode states (2-bit), derived from column_valid after each latch:
  - IDLE: no valid latch since reset.
  - TRACK: valid latch.
  - ERR: latch with column_valid = 0.
  - Transitions: IDLE→TRACK on a valid latch. TRACK→TRACK on a valid latch. TRACK→ERR on an invalid latch. ERR→TRACK on a valid latch.
  - State is internal only.
- Mid-frame reset discards the partial shift; the next frame starts from sr = 0.

Decomposition:
- Package column_select_pkg holds:
  - BITS_PER_COLUMN = 8
  - SEL_BIT = 0
  - EXTRA_BIT = 1
  - the decode-state typedef
- The transmitter side imports the same package.
- Sub-module serial_edge_sync: a per-signal synchronizer plus previous-value rising-edge detector, parameterised by SYNC_STAGES. Instanced for ser_clk, ser_stcp and ser_data (data uses only the delayed level), plus a level-only instance for ser_n_enable.

Test Plan:
- CHAIN_LEN=1, send 0xFE, then stcp → q=0xFE, latch_pulse once, column_idx=0, column_valid=1, extra_bit=1, frame_error=0.
- CHAIN_LEN=2, send 0xFE then 0xFF, then stcp → q=0xFEFF, column_idx=1, column_valid=1.
- Send 7 bits, then stcp → frame_error=1. Pulse err_clear → 0. Send 16 bits then stcp → frame_error stays 0.
- ser_stcp and ser_clk rising together after 8 bits 0xA5 → q holds the pre-shift value (0xA5 for CHAIN_LEN=1), bit_count=1 afterward.
- Drive ser_n_enable low → q_oe=1 after SYNC_STAGES+1 clk. Assert rst_n=0 mid-byte → all outputs 0 immediately (asynchronous), with no spurious latch_pulse on release while ser_stcp is held high.
- Latch 0x00 on CHAIN_LEN=2 → column_valid=0, column_idx unchanged from the previous valid latch.
